// File: rtl/lcd_write_scheduler_pkg.sv
// rtl/lcd_write_scheduler_pkg.sv - shared LCD scheduler state encodings and RS constants
package lcd_write_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } lcdState_t;

    localparam logic LCD_RS_CMD  = 1'b0;
    localparam logic LCD_RS_DATA = 1'b1;

    localparam int ENTRY_W = 9;

endpackage

// File: rtl/lcd_byte_fifo.sv
// rtl/lcd_byte_fifo.sv - 9-bit x DEPTH synchronous FIFO holding {rs, byte} entries
module lcd_byte_fifo
    import lcd_write_scheduler_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] head,
    output logic [AW:0]        count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wrPtr;
    logic [AW-1:0]      rdPtr;
    logic               doPush;
    logic               doPop;

    // A full queue refuses the push even if a pop happens on the same edge.
    assign doPush = push && (count != (AW+1)'(DEPTH));
    assign doPop  = pop && (count != '0);
    assign head   = mem[rdPtr];

    // Storage array is not reset; only pointers and count define validity.
    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_write_scheduler.sv
// rtl/lcd_write_scheduler.sv - queues CPU LCD byte writes and replays them to the LCD driver
module lcd_write_scheduler
    import lcd_write_scheduler_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          iWriteReq,
    input  logic          iRS,
    input  logic [7:0]    iData,
    input  logic          iLcdInitialized,
    input  logic          iLcdReady,
    output logic          oLcdWrite,
    output logic          oLcdRS,
    output logic [7:0]    oLcdData,
    output logic          oStall,
    output logic [AW:0]   oLevel,
    output logic          oOverflow,
    output logic          oTimeout
);

    localparam int            TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    lcdState_t          state;
    lcdState_t          nextState;
    logic [TW-1:0]      timer;
    logic [ENTRY_W-1:0] fifoHead;
    logic [AW:0]        fifoCount;
    logic               fifoFull;
    logic               popHead;
    logic               ackTimedOut;

    lcd_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uFifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (iWriteReq),
        .pop   (popHead),
        .din   ({iRS, iData}),
        .head  (fifoHead),
        .count (fifoCount)
    );

    assign fifoFull = (fifoCount == (AW+1)'(DEPTH));
    assign oStall   = fifoFull;
    assign oLevel   = fifoCount;

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; init only gates starting a transfer, never aborts one.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if ((fifoCount != '0) && iLcdInitialized && iLcdReady) begin
                    nextState = ISSUE;
                end
            end
            ISSUE:     nextState = WAIT_ACK;
            WAIT_ACK: begin
                if (!iLcdReady) begin
                    nextState = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    nextState = IDLE;
                end
            end
            WAIT_DONE: begin
                if (iLcdReady) begin
                    nextState = IDLE;
                end
            end
            default:   nextState = IDLE;
        endcase
    end

    // Output decode: strobe is state-derived; head leaves the queue only when its transfer ends.
    always_comb begin
        oLcdWrite   = (state == ISSUE);
        ackTimedOut = (state == WAIT_ACK) && iLcdReady && (timer == TIMER_LAST);
        popHead     = ackTimedOut || ((state == WAIT_DONE) && iLcdReady);
    end

    // Issued entry latch, acknowledge timer and sticky error flags.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oLcdRS    <= LCD_RS_CMD;
            oLcdData  <= '0;
            timer     <= '0;
            oOverflow <= 1'b0;
            oTimeout  <= 1'b0;
        end else begin
            if ((state == IDLE) && (nextState == ISSUE)) begin
                oLcdRS   <= fifoHead[8];
                oLcdData <= fifoHead[7:0];
            end else if (nextState == IDLE) begin
                oLcdRS   <= LCD_RS_CMD;
                oLcdData <= '0;
            end
            if ((state == WAIT_ACK) && iLcdReady && (timer != TIMER_LAST)) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
            if (iWriteReq && fifoFull) begin
                oOverflow <= 1'b1;
            end
            if (ackTimedOut) begin
                oTimeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// tb/tb_lcd_write_scheduler.sv - self-checking bench for lcd_write_scheduler
module tb_lcd_write_scheduler;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iWriteReq;
    logic       iRS;
    logic [7:0] iData;
    logic       iLcdInitialized;
    logic       iLcdReady;
    logic       oLcdWrite;
    logic       oLcdRS;
    logic [7:0] oLcdData;
    logic       oStall;
    logic [3:0] oLevel;
    logic       oOverflow;
    logic       oTimeout;

    logic       manReady;
    logic       busyMode;
    logic       stubReady = 1'b1;
    int         stubBusy = 5;
    int         busyCnt = 0;

    int         compared = 0;
    int         mismatched = 0;
    logic [8:0] obsQ [$];

    always #5 Clock = ~Clock;

    assign iLcdReady = busyMode ? stubReady : manReady;

    lcd_write_scheduler dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .iWriteReq       (iWriteReq),
        .iRS             (iRS),
        .iData           (iData),
        .iLcdInitialized (iLcdInitialized),
        .iLcdReady       (iLcdReady),
        .oLcdWrite       (oLcdWrite),
        .oLcdRS          (oLcdRS),
        .oLcdData        (oLcdData),
        .oStall          (oStall),
        .oLevel          (oLevel),
        .oOverflow       (oOverflow),
        .oTimeout        (oTimeout)
    );

    // Driver stub: goes busy for stubBusy cycles after each write strobe.
    always @(negedge Clock) begin
        if (oLcdWrite) begin
            stubReady = 1'b0;
            busyCnt   = stubBusy;
        end else if (busyCnt > 0) begin
            busyCnt = busyCnt - 1;
            if (busyCnt == 0) stubReady = 1'b1;
        end
    end

    // Records every byte the driver is handed.
    always @(negedge Clock) begin
        if (oLcdWrite) obsQ.push_back({oLcdRS, oLcdData});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        iRS       = rs;
        iData     = d;
        iWriteReq = 1'b1;
        cyc(1);
        iWriteReq = 1'b0;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        cyc(2);
        Reset = 1'b0;
        cyc(1);
    endtask

    task automatic waitStrobe(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (oLcdWrite === 1'b1) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic waitEmpty(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (oLevel === 4'd0) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        cyc(2);
    endtask

    task automatic checkDelivered(input string tag, input logic [8:0] exp[$], input int base);
        check({tag, "_count"}, 32'(obsQ.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < obsQ.size())
                check($sformatf("%s_%0d", tag, i), 32'(obsQ[base + i]), 32'(exp[i]));
        end
    endtask

    initial begin
        logic [8:0] expQ [$];
        logic [8:0] e;
        bit         seen;
        bit         ok;
        int         obsIdx;
        int         pushed;
        int         guard;

        Reset = 1'b1;
        iWriteReq = 1'b0;
        iRS = 1'b0;
        iData = 8'h00;
        iLcdInitialized = 1'b0;
        manReady = 1'b0;
        busyMode = 1'b0;
        cyc(2);
        check("rst_level", 32'(oLevel), 0);
        check("rst_write", 32'(oLcdWrite), 0);
        check("rst_stall", 32'(oStall), 0);
        check("rst_ovf", 32'(oOverflow), 0);
        check("rst_tmo", 32'(oTimeout), 0);
        Reset = 1'b0;
        cyc(1);

        // Reset while waiting for the acknowledge of an issued write.
        iLcdInitialized = 1'b1;
        manReady = 1'b1;
        push(1'b1, 8'h5A);
        waitStrobe(10, seen);
        check("t1_strobe_seen", 32'(seen), 1);
        check("t1_strobe_data", 32'(oLcdData), 32'h5A);
        cyc(1);
        check("t1_hold_data", 32'(oLcdData), 32'h5A);
        check("t1_single_strobe", 32'(oLcdWrite), 0);
        #2 Reset = 1'b1;
        #1;
        check("t1_async_write", 32'(oLcdWrite), 0);
        check("t1_async_data", 32'({oLcdRS, oLcdData}), 0);
        check("t1_async_level", 32'(oLevel), 0);
        @(negedge Clock);
        Reset = 1'b0;
        cyc(1);
        obsIdx = obsQ.size();

        // Pushes accepted before the driver is initialized; issued once it is.
        iLcdInitialized = 1'b0;
        busyMode = 1'b1;
        stubBusy = 5;
        push(1'b1, 8'h41);
        push(1'b1, 8'h42);
        cyc(10);
        check("t2_no_issue", 32'(obsQ.size() - obsIdx), 0);
        check("t2_level", 32'(oLevel), 2);
        iLcdInitialized = 1'b1;
        waitEmpty(200, ok);
        check("t2_drained", 32'(ok), 1);
        expQ = '{9'h141, 9'h142};
        checkDelivered("t2", expQ, obsIdx);
        check("t2_tmo", 32'(oTimeout), 0);
        obsIdx = obsQ.size();

        // Driver never drops ready: acknowledge timeout pops and moves on.
        busyMode = 1'b0;
        manReady = 1'b1;
        push(1'b0, 8'h11);
        push(1'b0, 8'h22);
        waitStrobe(10, seen);
        check("t3_strobe_seen", 32'(seen), 1);
        for (int i = 1; i <= 18; i++) begin
            cyc(1);
            if (i == 16) check("t3_tmo_before", 32'(oTimeout), 0);
            if (i == 17) begin
                check("t3_tmo_after", 32'(oTimeout), 1);
                check("t3_level_after", 32'(oLevel), 1);
            end
            if (i == 18) begin
                check("t3_next_strobe", 32'(oLcdWrite), 1);
                check("t3_next_data", 32'({oLcdRS, oLcdData}), 32'h022);
            end
        end
        waitEmpty(100, ok);
        check("t3_drained", 32'(ok), 1);
        doReset();
        obsIdx = obsQ.size();

        // Driver stuck busy: fill to DEPTH, overflow the ninth push, then drain.
        manReady = 1'b0;
        expQ = {};
        for (int i = 0; i < 9; i++) begin
            e = 9'($urandom);
            if (i < 8) expQ.push_back(e);
            if (i == 8) begin
                check("t4_stall_full", 32'(oStall), 1);
                check("t4_level_full", 32'(oLevel), 8);
                check("t4_ovf_before", 32'(oOverflow), 0);
            end
            push(e[8], e[7:0]);
        end
        check("t4_ovf_after", 32'(oOverflow), 1);
        check("t4_level_kept", 32'(oLevel), 8);
        busyMode = 1'b1;
        stubBusy = 3;
        waitEmpty(400, ok);
        check("t4_drained", 32'(ok), 1);
        checkDelivered("t4", expQ, obsIdx);
        check("t4_ovf_sticky", 32'(oOverflow), 1);
        check("t4_stall_clear", 32'(oStall), 0);
        doReset();
        obsIdx = obsQ.size();

        // Push lands on the same edge as a pop at level 3.
        busyMode = 1'b0;
        manReady = 1'b0;
        expQ = {};
        for (int i = 0; i < 3; i++) begin
            e = 9'($urandom);
            expQ.push_back(e);
            push(e[8], e[7:0]);
        end
        check("t5_level3", 32'(oLevel), 3);
        manReady = 1'b1;
        waitStrobe(10, seen);
        check("t5_strobe_seen", 32'(seen), 1);
        manReady = 1'b0;
        cyc(1);
        cyc(1);
        manReady = 1'b1;
        e = 9'($urandom);
        expQ.push_back(e);
        push(e[8], e[7:0]);
        check("t5_level_same", 32'(oLevel), 3);
        busyMode = 1'b1;
        stubBusy = 4;
        waitEmpty(300, ok);
        check("t5_drained", 32'(ok), 1);
        checkDelivered("t5", expQ, obsIdx);
        obsIdx = obsQ.size();

        // Random pushes against a 40-cycle busy driver.
        stubBusy = 40;
        expQ = {};
        pushed = 0;
        for (int k = 0; k < 20; k++) begin
            cyc($urandom_range(0, 30));
            guard = 0;
            while ((pushed - (obsQ.size() - obsIdx)) > 6 && guard < 2000) begin
                cyc(1);
                guard++;
            end
            e = 9'($urandom);
            expQ.push_back(e);
            push(e[8], e[7:0]);
            pushed++;
        end
        waitEmpty(3000, ok);
        check("t6_drained", 32'(ok), 1);
        checkDelivered("t6", expQ, obsIdx);
        check("t6_ovf", 32'(oOverflow), 0);
        check("t6_tmo", 32'(oTimeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
